// File: rtl/gcd_engine_if.sv
// Handshake bundle for gcd_engine: operands and start in, result and ready out.
// GCD_CYCLE_COUNT_EN adds the subtraction-count output.
interface gcd_engine_if #(
    parameter int NBits = 16
);
    logic             start;
    logic [NBits-1:0] xi;
    logic [NBits-1:0] yi;
    logic [NBits-1:0] xo;
    logic             rdy;
`ifdef GCD_CYCLE_COUNT_EN
    logic [NBits-1:0] cycles;

    modport master (output start, xi, yi, input xo, rdy, cycles);
    modport slave  (input start, xi, yi, output xo, rdy, cycles);
`else
    modport master (output start, xi, yi, input xo, rdy);
    modport slave  (input start, xi, yi, output xo, rdy);
`endif
endinterface

// File: rtl/gcd_engine.sv
// Iterative subtract-based GCD on signed operands, one subtraction per clock.
// GCD_CYCLE_COUNT_EN adds a saturating count of subtractions on bus.cycles.
module gcd_engine #(
    parameter int NBits = 16
) (
    input logic         clk,
    input logic         rst,
    gcd_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t           state_q;
    logic [NBits-1:0] x_q;
    logic [NBits-1:0] y_q;
    logic [NBits-1:0] xo_q;
    logic             rdy_q;
    logic [NBits-1:0] xa_d;
    logic [NBits-1:0] ya_d;

    // Negation mod 2^NBits, so the most negative input becomes 2^(NBits-1).
    always_comb begin
        xa_d = bus.xi[NBits-1] ? ('0 - bus.xi) : bus.xi;
        ya_d = bus.yi[NBits-1] ? ('0 - bus.yi) : bus.yi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xo_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b0;
                    if (bus.start) begin
                        x_q     <= xa_d;
                        y_q     <= ya_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (x_q == '0 || y_q == '0) begin
                        xo_q    <= '0;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (x_q > y_q) begin
                        x_q <= x_q - y_q;
                    end else if (y_q > x_q) begin
                        y_q <= y_q - x_q;
                    end else begin
                        xo_q    <= x_q;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        rdy_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.xo  = xo_q;
    assign bus.rdy = rdy_q;

`ifdef GCD_CYCLE_COUNT_EN
    logic [NBits-1:0] cnt_q;
    logic [NBits-1:0] cnt_d;

    always_comb begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + NBits'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            cnt_q <= '0;
        end else if (state_q == CALC && x_q != y_q) begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cycles = cnt_q;
`endif
endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: stimulus pushes expected results, a monitor
// checks each rising rdy against the queue head.
module tb_gcd_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    gcd_engine_if #(.NBits(16)) bus ();

    gcd_engine #(.NBits(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] exp;
        int          lat;
        int          subs;
        int          start_cyc;
    } item_t;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    item_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: each rising rdy must match the oldest pending operation.
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.rdy && !rdy_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy actual=1 required=0 xo=%0d", bus.xo);
            end else begin
                item_t it;
                it = sb.pop_front();
                check("result_xo", {16'd0, bus.xo}, {16'd0, it.exp});
                if (it.lat >= 0)
                    check("latency", cyc - it.start_cyc, it.lat);
`ifdef GCD_CYCLE_COUNT_EN
                check("cycles", {16'd0, bus.cycles}, it.subs);
`endif
            end
        end
        rdy_prev = bus.rdy;
    end

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] exp, input int lat);
        item_t it;
        int    limit;
        bit    got;
        @(negedge clk);
        bus.xi    = x;
        bus.yi    = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        it.exp       = exp;
        it.lat       = lat;
        it.subs      = (lat < 0) ? 0 : lat - 2;
        it.start_cyc = cyc;
        sb.push_back(it);
        // Operands change after capture; the engine must ignore them.
        bus.xi = 16'($urandom);
        bus.yi = 16'($urandom);
        limit  = ((lat < 0) ? 4 : lat) + 4;
        got    = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            if (bus.rdy) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL rdy_timeout actual=0 required=1 x=%0d y=%0d", x, y);
            sb.delete();
        end else begin
            repeat (2) @(posedge clk);
            #1;
            check("hold_rdy", {31'd0, bus.rdy}, 32'd1);
            check("hold_xo", {16'd0, bus.xo}, {16'd0, exp});
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        if (got) begin
            check("drop_rdy", {31'd0, bus.rdy}, 32'd0);
            check("idle_xo", {16'd0, bus.xo}, {16'd0, exp});
        end
    endtask

    function automatic int brute_gcd(input int a, input int b);
        int m;
        if (a == 0 || b == 0) return 0;
        m = (a < b) ? a : b;
        for (int d = m; d >= 1; d--)
            if (a % d == 0 && b % d == 0) return d;
        return 1;
    endfunction

    function automatic int sub_count(input int a, input int b);
        int n = 0;
        if (a == 0 || b == 0) return -1;
        while (a != b) begin
            if (a > b) a = a - b;
            else b = b - a;
            n++;
        end
        return n;
    endfunction

    vec_t vecs[] = '{
        '{13, 7, 16'd1, 9},
        '{620, 620, 16'd620, 2},
        '{0, 0, 16'd0, -1},
        '{5, 0, 16'd0, -1},
        '{42, 18, 16'd6, 6},
        '{18, 42, 16'd6, 6},
        '{-18, -42, 16'd6, 6},
        '{-18, 42, 16'd6, 6},
        '{18, -42, 16'd6, 6},
        '{-32768, 16384, 16'd16384, 3},
        '{-32768, -32768, 16'd32768, 2}
    };

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, g, s;
        bus.start = 1'b1;
        bus.xi    = 16'd9;
        bus.yi    = 16'd3;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        check("reset_xo", {16'd0, bus.xo}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rdy", {31'd0, bus.rdy}, 32'd0);

        foreach (vecs[i])
            run_op(16'(vecs[i].x), 16'(vecs[i].y), vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 100; i++) begin
            do begin
                a = int'($urandom_range(0, 32767));
                b = int'($urandom_range(0, 32767));
                s = sub_count(a, b);
            end while (s > 400);
            g = brute_gcd(a, b);
            run_op(16'(a), 16'(b), 16'(g), (s < 0) ? -1 : s + 2);
        end

        // Abort a long CALC with reset; no result may appear afterwards.
        run_op(16'd42, 16'd18, 16'd6, 6);
        @(negedge clk);
        bus.xi    = 16'd1;
        bus.yi    = 16'd30000;
        bus.start = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("midop_reset_rdy", {31'd0, bus.rdy}, 32'd0);
        check("midop_reset_xo", {16'd0, bus.xo}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("after_abort_rdy", {31'd0, bus.rdy}, 32'd0);

        run_op(16'd13, 16'd7, 16'd1, 9);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
